// File: rtl/bcd_multi_counter.sv
// Multi-digit BCD up/down counter with load, clear, cascade TC and sticky overflow.
// Optional feature: define BCD_SAT_EN to saturate at the terminal state instead of wrapping.
module bcd_multi_counter #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  Clear,
    input  logic                  Load,
    input  logic [4*DIGITS-1:0]   D,
    input  logic                  Count,
    input  logic                  Up,
    output logic [4*DIGITS-1:0]   Q,
    output logic                  TC,
    output logic                  Ovf
);

    logic [4*DIGITS-1:0] q_q, q_d;
    logic                ovf_q, ovf_d;
    logic                all9, all0, at_term;

    // Ripple step: a digit moves only while every lower digit sits at its rollover value.
    function automatic logic [4*DIGITS-1:0] bcd_step(input logic [4*DIGITS-1:0] v,
                                                     input logic up);
        logic [4*DIGITS-1:0] r;
        logic                en;
        logic [3:0]          dig;
        r  = v;
        en = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            dig = v[4*i +: 4];
            if (en) begin
                if (up) r[4*i +: 4] = (dig == 4'd9) ? 4'd0 : dig + 4'd1;
                else    r[4*i +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
            end
            en = en & (up ? (dig == 4'd9) : (dig == 4'd0));
        end
        return r;
    endfunction

    function automatic logic [4*DIGITS-1:0] bcd_sanitize(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd0 : v[4*i +: 4];
        end
        return r;
    endfunction

    always_comb begin
        all9 = 1'b1;
        all0 = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (q_q[4*i +: 4] != 4'd9) all9 = 1'b0;
            if (q_q[4*i +: 4] != 4'd0) all0 = 1'b0;
        end
    end

    assign at_term = Up ? all9 : all0;

    // Gated by reset so TC drops at once while reset is held, even at the all-0s state.
    assign TC = reset & Count & ~Clear & ~Load & at_term;

    always_comb begin
        q_d   = q_q;
        ovf_d = ovf_q;
        if (Clear) begin
            q_d   = '0;
            ovf_d = 1'b0;
        end else if (Load) begin
            q_d   = bcd_sanitize(D);
            ovf_d = 1'b0;
        end else if (Count) begin
            if (at_term) ovf_d = 1'b1;
`ifdef BCD_SAT_EN
            if (!at_term) q_d = bcd_step(q_q, Up);
`else
            q_d = bcd_step(q_q, Up);
`endif
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            q_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            ovf_q <= ovf_d;
        end
    end

    assign Q   = q_q;
    assign Ovf = ovf_q;

endmodule
